// File: rtl/cache_pkg.sv
// Shared types and constants for the 4-way cache lookup/replacement path.
// Set width is fixed by the cache_LRU address width.
package cache_pkg;

  localparam int SET_W     = 11;
  localparam int WAYS      = 4;
  localparam int WAY_IDX_W = 2;
  localparam int DEF_TAG_W = 13;

  typedef struct packed {
    logic                 valid;
    logic [DEF_TAG_W-1:0] tag;
  } tag_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS_REQ,
    ST_FILL_WAIT,
    ST_UPDATE
  } way_sel_state_t;

endpackage

// File: rtl/cache_tag_compare.sv
// Combinational 4-way tag compare: hit way (lowest index wins on duplicates)
// and lowest-numbered invalid way.
module cache_tag_compare
  import cache_pkg::*;
#(
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic [WAYS*(TAG_W+1)-1:0] i_ways,
  input  logic [TAG_W-1:0]          i_tag,
  output logic                      o_hit,
  output logic [WAY_IDX_W-1:0]      o_hit_way,
  output logic                      o_any_invalid,
  output logic [WAY_IDX_W-1:0]      o_first_invalid
);

  logic [WAYS-1:0] w_match;
  logic [WAYS-1:0] w_invalid;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign w_invalid[w] = ~i_ways[w*(TAG_W+1) + TAG_W];
    assign w_match[w]   = i_ways[w*(TAG_W+1) + TAG_W] &&
                          (i_ways[w*(TAG_W+1) +: TAG_W] == i_tag);
  end

  // Scan from the top way down so the lowest matching index is written last.
  always_comb begin
    o_hit_way       = '0;
    o_first_invalid = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_match[w]) o_hit_way = WAY_IDX_W'(w);
      if (w_invalid[w]) o_first_invalid = WAY_IDX_W'(w);
    end
  end

  assign o_hit         = |w_match;
  assign o_any_invalid = |w_invalid;

endmodule

// File: rtl/cache_way_select.sv
// Lookup/replacement controller in front of cache_LRU and the tag RAM.
// Define CACHE_WAY_SEL_INVALID_FIRST_EN to prefer invalid ways as miss victims.
module cache_way_select
  import cache_pkg::*;
#(
  parameter int TAG_W = DEF_TAG_W
) (
  input  logic                      main_clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [SET_W-1:0]          req_set,
  input  logic [TAG_W-1:0]          req_tag,
  output logic [SET_W-1:0]          tag_rd_addr,
  input  logic [WAYS*(TAG_W+1)-1:0] tag_rd_data,
  output logic                      tag_wr_en,
  output logic [WAY_IDX_W-1:0]      tag_wr_way,
  output logic [TAG_W:0]            tag_wr_data,
  output logic [SET_W-1:0]          lru_addr,
  output logic [WAY_IDX_W-1:0]      lru_used_index,
  output logic                      lru_enable_write,
  input  logic [WAY_IDX_W-1:0]      lru_least_used,
  output logic                      fill_valid,
  input  logic                      fill_ready,
  output logic [SET_W-1:0]          fill_set,
  output logic [TAG_W-1:0]          fill_tag,
  output logic [WAY_IDX_W-1:0]      fill_way,
  input  logic                      fill_done,
  output logic                      resp_valid,
  output logic                      resp_hit,
  output logic [WAY_IDX_W-1:0]      resp_way
);

  way_sel_state_t         r_state, w_nextState;
  logic [SET_W-1:0]       r_set;
  logic [TAG_W-1:0]       r_tag;
  logic [WAY_IDX_W-1:0]   r_victim;
  logic                   w_hit;
  logic [WAY_IDX_W-1:0]   w_hitWay;
  logic                   w_anyInvalid;
  logic [WAY_IDX_W-1:0]   w_firstInvalid;
  logic [WAY_IDX_W-1:0]   w_victim;

  cache_tag_compare #(.TAG_W(TAG_W)) u_compare (
    .i_ways         (tag_rd_data),
    .i_tag          (r_tag),
    .o_hit          (w_hit),
    .o_hit_way      (w_hitWay),
    .o_any_invalid  (w_anyInvalid),
    .o_first_invalid(w_firstInvalid)
  );

`ifdef CACHE_WAY_SEL_INVALID_FIRST_EN
  assign w_victim = w_anyInvalid ? w_firstInvalid : lru_least_used;
`else
  logic w_unusedInvalid;
  assign w_victim        = lru_least_used;
  assign w_unusedInvalid = w_anyInvalid ^ (^w_firstInvalid);
`endif

  always_ff @(posedge main_clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_set    <= '0;
      r_tag    <= '0;
      r_victim <= '0;
    end else begin
      r_state <= w_nextState;
      if (r_state == ST_IDLE && req_valid) begin
        r_set <= req_set;
        r_tag <= req_tag;
      end
      if (r_state == ST_LOOKUP && !w_hit) r_victim <= w_victim;
    end
  end

  // The accept cycle forwards req_set straight to both RAM-like neighbours so
  // their registered read data lines up with LOOKUP.
  always_comb begin
    w_nextState      = r_state;
    req_ready        = 1'b0;
    tag_rd_addr      = r_set;
    lru_addr         = r_set;
    lru_used_index   = '0;
    lru_enable_write = 1'b0;
    tag_wr_en        = 1'b0;
    tag_wr_way       = '0;
    tag_wr_data      = '0;
    fill_valid       = 1'b0;
    resp_valid       = 1'b0;
    resp_hit         = 1'b0;
    resp_way         = '0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          tag_rd_addr = req_set;
          lru_addr    = req_set;
          w_nextState = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (w_hit) begin
          resp_valid       = 1'b1;
          resp_hit         = 1'b1;
          resp_way         = w_hitWay;
          lru_used_index   = w_hitWay;
          lru_enable_write = 1'b1;
          w_nextState      = ST_IDLE;
        end else begin
          w_nextState = ST_MISS_REQ;
        end
      end
      ST_MISS_REQ: begin
        fill_valid = 1'b1;
        if (fill_ready) w_nextState = ST_FILL_WAIT;
      end
      ST_FILL_WAIT: begin
        if (fill_done) w_nextState = ST_UPDATE;
      end
      ST_UPDATE: begin
        tag_wr_en        = 1'b1;
        tag_wr_way       = r_victim;
        tag_wr_data      = {1'b1, r_tag};
        lru_used_index   = r_victim;
        lru_enable_write = 1'b1;
        resp_valid       = 1'b1;
        resp_way         = r_victim;
        w_nextState      = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  assign fill_set = r_set;
  assign fill_tag = r_tag;
  assign fill_way = r_victim;

endmodule

// File: doc/cache_way_select.md
Name: cache_way_select

Overview:
- Lookup and replacement controller for the 4-way set-associative cache.
- Sits directly upstream of cache_LRU:
  - drives its addr, used_index and enable_write;
  - consumes least_used_index to choose a victim on a miss.
- Reads and writes the external tag RAM.
- Issues line-fill requests to the DRAM controller.
- Reports hit/fill way to the data-array stage.

Parameters:
TAG_W, 13, tag width per way (stored tag RAM entry is TAG_W+1 bits incl. valid)
SET_W, 11, set index width; fixed at 11 to match cache_LRU addr

Ports:
main_clk  in  1  sole clock
rst  in  1  synchronous active-high reset
req_valid  in  1  lookup request present
req_ready  out  1  block accepts request this cycle
req_set  in  SET_W  set index of request
req_tag  in  TAG_W  tag of request
tag_rd_addr  out  SET_W  tag RAM read address (registered RAM, 1-cycle latency)
tag_rd_data  in  4*(TAG_W+1)  way3..way0, each {valid,tag}
tag_wr_en  out  1  tag RAM write strobe
tag_wr_way  out  2  way written
tag_wr_data  out  TAG_W+1  {1'b1,tag} written on fill
lru_addr  out  SET_W  to cache_LRU addr
lru_used_index  out  2  to cache_LRU used_index
lru_enable_write  out  1  to cache_LRU enable_write
lru_least_used  in  2  from cache_LRU least_used_index; valid cycle after lru_addr presented
fill_valid  out  1  line-fill request to DRAM controller
fill_ready  in  1  DRAM controller accepts fill
fill_set  out  SET_W  fill set
fill_tag  out  TAG_W  fill tag
fill_way  out  2  destination way
fill_done  in  1  one-cycle pulse: line data written
resp_valid  out  1  one-cycle pulse: lookup complete
resp_hit  out  1  1=hit, 0=serviced miss
resp_way  out  2  way holding the line

Behaviour:
- Reset values:
  - req_ready=1; all other outputs 0.
  - State IDLE; tag_rd_addr, lru_addr and fill_set/tag/way = 0.
- Reset mid-operation:
  - Any state returns to IDLE next cycle.
  - fill_valid drops; an outstanding fill_done is ignored.
- States: IDLE, LOOKUP, MISS_REQ, FILL_WAIT, UPDATE.
- IDLE:
  - req_ready=1.
  - On req_valid: latch set/tag; drive tag_rd_addr=req_set and lru_addr=req_set with lru_enable_write=0 (probe).
  - Go to LOOKUP.
  - req_ready=0 in every other state.
- LOOKUP (cycle after accept; tag_rd_data and lru_least_used valid):
  - Compare all 4 ways: hit = valid & tag match.
  - If multiple ways match, the lowest-numbered way wins.
  - On hit: resp_valid=1, resp_hit=1, resp_way=hit way; same cycle drive lru_addr=set, lru_used_index=hit way, lru_enable_write=1; go to IDLE.
  - On miss: victim=lru_least_used; register victim; go to MISS_REQ.
- MISS_REQ:
  - fill_valid=1 with set/tag/victim held stable until fill_ready.
  - On fill_valid&fill_ready, go to FILL_WAIT.
- FILL_WAIT:
  - Wait for fill_done; there is no timeout.
  - fill_done in any other state is ignored.
- UPDATE (entered the cycle after fill_done):
  - tag_wr_en=1, tag_wr_way=victim, tag_wr_data={1,tag}.
  - lru_addr=set, lru_used_index=victim, lru_enable_write=1.
  - resp_valid=1, resp_hit=0, resp_way=victim.
  - Go to IDLE.
- Back-to-back:
  - A new request may be accepted the cycle after a touch (IDLE).
  - cache_LRU read-through-write forwarding makes an immediate same-set probe see the updated permutation; no bubble is inserted.
- Latency:
  - Hit: resp 1 cycle after accept.
  - Miss: resp 1 cycle after fill_done.
- Only one outstanding request; there is no queuing.

Optional Feature:
- Macro CACHE_WAY_SEL_INVALID_FIRST_EN.
- Defined: on a miss, if any way has valid=0, the victim is the lowest-numbered invalid way; otherwise lru_least_used.
- Undefined: the victim is always lru_least_used, and valid bits affect only hit detection.

Decomposition:
- Package cache_pkg:
  - SET_W=11, WAYS=4, WAY_IDX_W=2.
  - Typedef tag_entry_t {logic valid; logic [TAG_W-1:0] tag}.
  - State enum way_sel_state_t.
- Sub-module cache_tag_compare: combinational 4-way compare giving hit and hit_way with lowest-index priority, plus first-invalid way and any_invalid.

Test Plan:
- Reset, then req set=0x12A tag=0x0055 with way2 = {1,0x0055}:
  - resp_valid 1 cycle later, hit=1, way=2.
  - Same cycle: lru_enable_write=1, lru_used_index=2, lru_addr=0x12A.
- Miss on set 0x005, all ways valid, lru_least_used=3:
  - fill_valid with way=3.
  - Hold fill_ready=0 for 4 cycles; fill fields stay stable.
  - fill_ready=1, then fill_done.
  - Next cycle: tag_wr_en way3 data {1,tag}, LRU touch way3, resp hit=0 way=3.
- Macro on, set with way1 invalid and lru_least_used=0:
  - Victim is 1.
  - Same stimulus with macro off: victim is 0.
- Two back-to-back hits to the same set, ways 0 then 1:
  - Second req accepted the cycle after the first resp.
  - Two LRU touches in consecutive accesses.
  - A following miss picks the cache_LRU-reported victim, excluding ways 0 and 1.
- Assert rst in FILL_WAIT, then pulse fill_done:
  - Next cycle: IDLE, req_ready=1, no tag_wr_en, no resp_valid.
- Duplicate tag match in ways 1 and 3: hit reports way=1.
